// File: rtl/tmr0_wdt_pkg.sv
// Shared OPTION-register layout, reset constants and prescaler mask helper for Timer0/WDT.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
package tmr0_wdt_pkg;

    // OPTION register bit positions: {T0CS, T0SE, PSA, PS[2:0]}
    localparam int OPT_T0CS   = 5;
    localparam int OPT_T0SE   = 4;
    localparam int OPT_PSA    = 3;
    localparam int OPT_PS_MSB = 2;
    localparam int OPT_PS_LSB = 0;

    localparam logic [5:0] OPTION_RESET = 6'h3F;

    // Register-file address of TMR0; the execute stage decodes it into tmr0WriteIn.
    localparam logic [4:0] TMR0_ADDR = 5'h01;

    // Mask = ratio - 1. TMR0 assignment divides by 2^(PS+1), WDT assignment by 2^PS.
    function automatic logic [7:0] psMask(input logic psa, input logic [2:0] ps);
        logic [3:0] shamt;
        logic [8:0] full;
        shamt = psa ? {1'b0, ps} : ({1'b0, ps} + 4'd1);
        full  = (9'd1 << shamt) - 9'd1;
        return full[7:0];
    endfunction

endpackage

// File: rtl/tmr0_wdt_if.sv
// Core-side bundle between execute/write-back and the Timer0/WDT block.
// Latency: n/a (wires only).
// Backpressure: none; strobes are single-clk pulses that are always accepted.
interface tmr0_wdt_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  instCycleIn;
    logic                  tmr0WriteIn;
    logic                  optionWriteIn;
    logic                  clrwdtIn;
    logic [DATA_WIDTH-1:0] dataIn;
    logic [DATA_WIDTH-1:0] tmr0Out;
    logic [5:0]            optionOut;
    logic                  wdtTimeoutOut;

    // Core side: drives strobes and write data, reads back timer state.
    modport master (
        output instCycleIn, tmr0WriteIn, optionWriteIn, clrwdtIn, dataIn,
        input  tmr0Out, optionOut, wdtTimeoutOut
    );

    // Timer side.
    modport slave (
        input  instCycleIn, tmr0WriteIn, optionWriteIn, clrwdtIn, dataIn,
        output tmr0Out, optionOut, wdtTimeoutOut
    );
endinterface

// File: rtl/tmr0_wdt_edge_sync.sv
// edge_sync: 2-flop synchroniser plus selectable-polarity edge detector for an async pin.
// Latency: edge pulse asserted 2 clk after the pin edge; one clk wide.
// Backpressure: none; pin pulses narrower than 2 clk may be missed.
module tmr0_wdt_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic asyncIn,
    input  logic fallSel,
    output logic edgePulse
);
    logic sync1;
    logic sync2;
    logic prevLvl;

    // Two synchroniser stages followed by the previous-level register used for edge compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            prevLvl <= 1'b0;
        end else begin
            sync1   <= asyncIn;
            sync2   <= sync1;
            prevLvl <= sync2;
        end
    end

    assign edgePulse = fallSel ? (prevLvl & ~sync2) : (~prevLvl & sync2);

endmodule

// File: rtl/tmr0_wdt.sv
// Timer0 + watchdog: OPTION register, TMR0 counter, shared 8-bit prescaler and WDT.
// Latency: TMR0 write/increment visible 1 clk after the strobe; T0CKI edge -> increment 3 clk.
// Backpressure: none; events during the 2-instruction-cycle post-write inhibit are dropped.
module tmr0_wdt
    import tmr0_wdt_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int WDT_BASE   = 256
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           t0ckiIn,
    input  logic           wdtEnIn,
    tmr0_wdt_if.slave      bus
);
    localparam int WBW = (WDT_BASE > 2) ? $clog2(WDT_BASE) : 1;
    localparam logic [WBW-1:0] WDT_LAST = WBW'(WDT_BASE - 1);

    logic [5:0]            optReg;
    logic [7:0]            psCnt;
    logic [DATA_WIDTH-1:0] tmr0Q;
    logic [1:0]            inhCnt;
    logic [WBW-1:0]        wdtBase;
    logic                  timeoutQ;

    logic       t0cs;
    logic       t0se;
    logic       psa;
    logic [2:0] ps;
    logic       extEdge;
    logic       rawEvt;
    logic       qualEvt;
    logic       baseTick;
    logic       psEvt;
    logic [7:0] psMaskV;
    logic       psTick;
    logic       finalTick;
    logic       wdtFire;
    logic       psClear;
    logic       tmrInc;

    assign t0cs = optReg[OPT_T0CS];
    assign t0se = optReg[OPT_T0SE];
    assign psa  = optReg[OPT_PSA];
    assign ps   = optReg[OPT_PS_MSB:OPT_PS_LSB];

    tmr0_wdt_edge_sync uEdge (
        .clk       (clk),
        .rst_n     (rst_n),
        .asyncIn   (t0ckiIn),
        .fallSel   (t0se),
        .edgePulse (extEdge)
    );

    // Event path: pick the clock source, then drop events while a TMR0 write inhibit is pending.
    assign rawEvt  = t0cs ? extEdge : bus.instCycleIn;
    assign qualEvt = rawEvt & (inhCnt == 2'd0);

    // WDT base tick is the wrap of the base counter; the counter is idle when the fuse is off.
    assign baseTick = wdtEnIn & bus.instCycleIn & (wdtBase == WDT_LAST);

    // Prescaler input and tap, shared between TMR0 and WDT according to PSA.
    assign psEvt   = psa ? baseTick : qualEvt;
    assign psMaskV = psMask(psa, ps);
    assign psTick  = psEvt & ((psCnt & psMaskV) == psMaskV);

    // A CLRWDT in the same clk as the final tick suppresses the time-out.
    assign finalTick = psa ? psTick : baseTick;
    assign wdtFire   = finalTick & wdtEnIn & ~bus.clrwdtIn;

    // Any prescaler clear wins over a same-clk increment.
    assign psClear = (bus.optionWriteIn & (bus.dataIn[OPT_PSA] != psa))
                   | (bus.tmr0WriteIn & ~psa)
                   | ((bus.clrwdtIn | wdtFire) & psa);

    assign tmrInc = psa ? qualEvt : psTick;

    // OPTION register load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            optReg <= OPTION_RESET;
        else if (bus.optionWriteIn)
            optReg <= bus.dataIn[5:0];
    end

    // Post-write inhibit: armed by a TMR0 write, counts down on instruction cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            inhCnt <= 2'd0;
        else if (bus.tmr0WriteIn)
            inhCnt <= 2'd2;
        else if (bus.instCycleIn && inhCnt != 2'd0)
            inhCnt <= inhCnt - 2'd1;
    end

    // Free-running prescaler; wrap from 0xFF is silent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            psCnt <= 8'd0;
        else if (psClear)
            psCnt <= 8'd0;
        else if (psEvt)
            psCnt <= psCnt + 8'd1;
    end

    // TMR0: a write beats a same-clk increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmr0Q <= '0;
        else if (bus.tmr0WriteIn)
            tmr0Q <= bus.dataIn;
        else if (tmrInc)
            tmr0Q <= tmr0Q + 1'b1;
    end

    // WDT base counter: held at 0 when disabled, cleared by CLRWDT or a time-out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wdtBase <= '0;
        else if (!wdtEnIn || bus.clrwdtIn || wdtFire)
            wdtBase <= '0;
        else if (bus.instCycleIn)
            wdtBase <= (wdtBase == WDT_LAST) ? '0 : wdtBase + 1'b1;
    end

    // Registered one-clk time-out pulse to the reset logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            timeoutQ <= 1'b0;
        else
            timeoutQ <= wdtFire;
    end

    assign bus.tmr0Out       = tmr0Q;
    assign bus.optionOut     = optReg;
    assign bus.wdtTimeoutOut = timeoutQ;

endmodule

// File: tb/tb_tmr0_wdt.sv
// Bench for tmr0_wdt: scoreboard of expected values pushed at stimulus, popped at sample.
// Latency: samples 1 ns after each active clock edge.
// Backpressure: n/a.
module tb_tmr0_wdt;
    logic clk = 1'b0;
    logic rst_n;
    logic t0cki;
    logic t0Level;
    logic wdtEn;

    tmr0_wdt_if #(.DATA_WIDTH(8)) bus ();

    tmr0_wdt #(.DATA_WIDTH(8), .WDT_BASE(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .t0ckiIn (t0cki),
        .wdtEnIn (wdtEn),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [7:0] expQ[$];
    string      tagQ[$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s: got %02h want %02h", tag, obs, want);
        end
    endtask

    task automatic pushExp(input string tag, input logic [7:0] v);
        tagQ.push_back(tag);
        expQ.push_back(v);
    endtask

    task automatic popChk(input logic [7:0] obs);
        string t;
        logic [7:0] w;
        if (expQ.size() == 0) begin
            bad++;
            $display("FAIL sb_underflow: got %02h with nothing expected", obs);
        end else begin
            t = tagQ.pop_front();
            w = expQ.pop_front();
            chk(t, obs, w);
        end
    endtask

    // One clk of stimulus: inputs set on the falling edge, strobes dropped after the rising edge.
    task automatic clkStep(input logic ic, input logic tw, input logic ow, input logic cw,
                           input logic [7:0] d);
        @(negedge clk);
        bus.instCycleIn   = ic;
        bus.tmr0WriteIn   = tw;
        bus.optionWriteIn = ow;
        bus.clrwdtIn      = cw;
        bus.dataIn        = d;
        t0cki             = t0Level;
        @(posedge clk);
        #1;
        bus.instCycleIn   = 1'b0;
        bus.tmr0WriteIn   = 1'b0;
        bus.optionWriteIn = 1'b0;
        bus.clrwdtIn      = 1'b0;
    endtask

    task automatic idle();
        clkStep(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // Instruction cycle: one quiet clk, then the Q4 pulse clk.
    task automatic icyc();
        idle();
        clkStep(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic writeOpt(input logic [7:0] v);
        clkStep(1'b0, 1'b0, 1'b1, 1'b0, v);
        pushExp("opt_load", v);
        popChk({2'b00, bus.optionOut});
    endtask

    task automatic hardReset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic checkResetState(input string tag);
        pushExp({tag, "_tmr0"}, 8'h00);
        popChk(bus.tmr0Out);
        pushExp({tag, "_opt"}, 8'h3F);
        popChk({2'b00, bus.optionOut});
        pushExp({tag, "_wdt"}, 8'h00);
        popChk({7'b0, bus.wdtTimeoutOut});
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no end want end");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst_n             = 1'b0;
        t0Level           = 1'b0;
        t0cki             = 1'b0;
        wdtEn             = 1'b0;
        bus.instCycleIn   = 1'b0;
        bus.tmr0WriteIn   = 1'b0;
        bus.optionWriteIn = 1'b0;
        bus.clrwdtIn      = 1'b0;
        bus.dataIn        = 8'h00;
        #12;
        checkResetState("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Internal clock, prescaler on WDT with ratio 1: TMR0 counts every instruction cycle.
        writeOpt(8'h08);
        for (int k = 1; k <= 300; k++) begin
            icyc();
            pushExp("byp_cnt", 8'(k));
            popChk(bus.tmr0Out);
        end
        pushExp("byp_300", 8'h2C);
        popChk(bus.tmr0Out);

        // Write coinciding with an event: loaded value held, then two inhibited cycles.
        clkStep(1'b1, 1'b1, 1'b0, 1'b0, 8'h80);
        pushExp("wr_vs_evt", 8'h80);
        popChk(bus.tmr0Out);
        for (int k = 1; k <= 3; k++) begin
            icyc();
            pushExp("wr_inhibit", (k < 3) ? 8'h80 : 8'h81);
            popChk(bus.tmr0Out);
        end

        // Prescaler on TMR0, ratio 4.
        hardReset();
        writeOpt(8'h01);
        for (int k = 1; k <= 10; k++) begin
            icyc();
            pushExp("ps4_cnt", 8'(k / 4));
            popChk(bus.tmr0Out);
        end
        clkStep(1'b0, 1'b1, 1'b0, 1'b0, 8'hFE);
        pushExp("ps4_wr", 8'hFE);
        popChk(bus.tmr0Out);
        for (int k = 1; k <= 10; k++) begin
            icyc();
            pushExp("ps4_wrap", (k <= 5) ? 8'hFE : ((k <= 9) ? 8'hFF : 8'h00));
            popChk(bus.tmr0Out);
        end

        // External clock, falling edge, no prescale: increment 3 clk after each fall.
        hardReset();
        writeOpt(8'h38);
        for (int p = 1; p <= 5; p++) begin
            t0Level = 1'b1;
            for (int c = 1; c <= 4; c++) begin
                idle();
                pushExp("ext_hi", 8'(p - 1));
                popChk(bus.tmr0Out);
            end
            t0Level = 1'b0;
            for (int c = 1; c <= 4; c++) begin
                idle();
                pushExp("ext_lo", (c >= 3) ? 8'(p) : 8'(p - 1));
                popChk(bus.tmr0Out);
            end
        end
        pushExp("ext_total", 8'h05);
        popChk(bus.tmr0Out);

        // Asynchronous reset away from any clock edge, while counted up.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetState("async");
        @(negedge clk);
        wdtEn = 1'b1;
        rst_n = 1'b1;

        // WDT base 4, prescaler ratio 2 on WDT: time-out after instruction cycle 8 only.
        writeOpt(8'h09);
        for (int k = 1; k <= 12; k++) begin
            clkStep(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            pushExp("wdt_pulse", (k == 8) ? 8'h01 : 8'h00);
            popChk({7'b0, bus.wdtTimeoutOut});
            idle();
            pushExp("wdt_quiet", 8'h00);
            popChk({7'b0, bus.wdtTimeoutOut});
        end

        // CLRWDT every 6 instruction cycles keeps the watchdog quiet.
        hardReset();
        writeOpt(8'h09);
        for (int k = 1; k <= 30; k++) begin
            clkStep(1'b1, 1'b0, 1'b0, (k % 6 == 0), 8'h00);
            pushExp("clrwdt", 8'h00);
            popChk({7'b0, bus.wdtTimeoutOut});
            idle();
            pushExp("clrwdt_idle", 8'h00);
            popChk({7'b0, bus.wdtTimeoutOut});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
